vermirq_controller: RTL and testbench

- Interrupt controller on the request side of the core's IRQ interface.
- Collects N external interrupt sources (level or rising-edge, per source), masks them with a software enable register and drives the single `irq` line into the core.
- Tracks the core's handshake: the core accepts (`irq_ack`), then returns with mret (`mret`). Only one interrupt is in service at a time.
- Memory-mapped on the system bus so the handler can read the cause and clear pending bits.

---
 rtl/vermirq_pkg.sv | 21 ++
 rtl/vermirq_sync.sv | 34 +++
 rtl/vermirq_controller.sv | 150 +++++++++++++++
 tb/tb_vermirq_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vermirq_pkg.sv
// Shared types and constants for the vermirq interrupt controller.
package vermirq_pkg;

  typedef logic [31:0] word_t;

  // Word offsets within the register window, decoded from address[3:2].
  localparam logic [1:0] IRQ_PENDING = 2'd0;
  localparam logic [1:0] IRQ_ENABLE  = 2'd1;
  localparam logic [1:0] IRQ_CAUSE   = 2'd2;
  localparam logic [1:0] IRQ_EDGE    = 2'd3;

  // CAUSE bit that reports an interrupt currently being serviced.
  localparam int CAUSE_INSERVICE_BIT = 31;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQUEST    = 2'd1,
    IN_SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/vermirq_sync.sv
// Multi-flop bit-vector synchronizer; STAGES=0 passes the input straight through.
module vermirq_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  if (STAGES == 0) begin : g_bypass
    // Sources already live in the clk domain.
    assign sync_out = async_in;

    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
  end else begin : g_chain
    logic [WIDTH-1:0] stage_reg [STAGES];

    // Shift the raw vector through STAGES flops.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < STAGES; i++) stage_reg[i] <= '0;
      end else begin
        stage_reg[0] <= async_in;
        for (int i = 1; i < STAGES; i++) stage_reg[i] <= stage_reg[i-1];
      end
    end

    assign sync_out = stage_reg[STAGES-1];
  end

endmodule

// File: rtl/vermirq_controller.sv
// Interrupt controller: gathers level/edge sources, masks them and runs the
// single-request irq handshake with the core (request, ack, mret).
module vermirq_controller
  import vermirq_pkg::*;
#(
  parameter int N_SOURCES   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SOURCES-1:0] sources,
  input  logic                 valid,
  output logic                 ready,
  input  logic [31:0]          address,
  input  logic [3:0]           wstrobe,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic                 irq_ack,
  input  logic                 mret,
  output logic                 irq
);

  // Lowest set index wins, so source 0 has the highest priority.
  function automatic logic [4:0] lowest_set(input logic [N_SOURCES-1:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = N_SOURCES - 1; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  logic [N_SOURCES-1:0] src_sync;
  logic [N_SOURCES-1:0] src_prev_reg;
  logic [N_SOURCES-1:0] pending_reg, pending_next;
  logic [N_SOURCES-1:0] enable_reg;
  logic [N_SOURCES-1:0] edge_mode_reg;
  logic [N_SOURCES-1:0] active;
  logic [N_SOURCES-1:0] rise;
  logic [N_SOURCES-1:0] w1c_clear;
  logic [N_SOURCES-1:0] wmask_n;
  logic [N_SOURCES-1:0] wdata_n;
  logic [4:0]           cause_reg, cause_next;
  irq_state_t           state_reg, state_next;
  word_t                byte_mask;
  logic                 wr_en;
  logic [1:0]           reg_sel;
  logic                 unused_bits;

  vermirq_sync #(
    .WIDTH  (N_SOURCES),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (sources),
    .sync_out (src_sync)
  );

  // Bus decode: only address[3:2] selects a register; strobes act per byte.
  assign reg_sel   = address[3:2];
  assign wr_en     = valid && (wstrobe != 4'b0000);
  assign byte_mask = {{8{wstrobe[3]}}, {8{wstrobe[2]}}, {8{wstrobe[1]}}, {8{wstrobe[0]}}};
  assign wmask_n   = byte_mask[N_SOURCES-1:0];
  assign wdata_n   = wdata[N_SOURCES-1:0] & wmask_n;
  assign w1c_clear = (wr_en && reg_sel == IRQ_PENDING) ? wdata_n : '0;
  assign rise      = src_sync & ~src_prev_reg;
  assign active    = pending_reg & enable_reg;
  assign ready     = valid;
  assign irq       = (state_reg == REQUEST);

  assign unused_bits = ^{address[31:4], address[1:0], wdata[31:N_SOURCES],
                         byte_mask[31:N_SOURCES]};

  // Per-source pending: edge bits latch rises (a new rise beats W1C), level bits follow the line.
  for (genvar gi = 0; gi < N_SOURCES; gi++) begin : g_pending
    assign pending_next[gi] = edge_mode_reg[gi]
                              ? (rise[gi] | (pending_reg[gi] & ~w1c_clear[gi]))
                              : src_sync[gi];
  end

  // Source history, pending bits and software-writable registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_prev_reg  <= '0;
      pending_reg   <= '0;
      enable_reg    <= '0;
      edge_mode_reg <= '0;
    end else begin
      src_prev_reg <= src_sync;
      pending_reg  <= pending_next;
      if (wr_en && reg_sel == IRQ_ENABLE)
        enable_reg <= (enable_reg & ~wmask_n) | wdata_n;
      if (wr_en && reg_sel == IRQ_EDGE)
        edge_mode_reg <= (edge_mode_reg & ~wmask_n) | wdata_n;
    end
  end

  // Handshake state and latched cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cause_reg <= '0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
    end
  end

  // Next-state logic: ack takes priority over mret; withdrawn requests fall back to IDLE.
  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    case (state_reg)
      IDLE: begin
        if (|active) state_next = REQUEST;
      end
      REQUEST: begin
        if (irq_ack) begin
          cause_next = lowest_set(active);
          state_next = IN_SERVICE;
        end else if (active == '0) begin
          state_next = IDLE;
        end
      end
      IN_SERVICE: begin
        if (mret && !irq_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Combinational read mux; unused high bits read as zero.
  always_comb begin
    rdata = '0;
    if (valid) begin
      case (reg_sel)
        IRQ_PENDING: rdata = word_t'(pending_reg);
        IRQ_ENABLE:  rdata = word_t'(enable_reg);
        IRQ_CAUSE: begin
          rdata[CAUSE_INSERVICE_BIT] = (state_reg == IN_SERVICE);
          rdata[4:0]                 = cause_reg;
        end
        IRQ_EDGE:    rdata = word_t'(edge_mode_reg);
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vermirq_controller.sv
// Scoreboard bench for vermirq_controller: stimulus queues expected read data
// and irq levels; a negedge monitor compares whenever a read or probe is presented.
module tb_vermirq_controller;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] sources = '0;
  logic         valid = 1'b0;
  logic         ready;
  logic [31:0]  address = '0;
  logic [3:0]   wstrobe = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         irq_ack = 1'b0;
  logic         mret = 1'b0;
  logic         irq;
  logic         probe = 1'b0;
  logic         done = 1'b0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t rd_q[$];
  exp_t irq_q[$];
  int   n_cmp  = 0;
  int   n_mism = 0;

  vermirq_controller #(
    .N_SOURCES   (N),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sources (sources),
    .valid   (valid),
    .ready   (ready),
    .address (address),
    .wstrobe (wstrobe),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq_ack (irq_ack),
    .mret    (mret),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Advance one cycle; per-cycle strobes are single-cycle pulses.
  task automatic step();
    @(posedge clk);
    #1;
    valid   = 1'b0;
    wstrobe = 4'b0000;
    probe   = 1'b0;
    irq_ack = 1'b0;
    mret    = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    valid   = 1'b1;
    address = a;
    wdata   = d;
    wstrobe = s;
    step();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    rd_q.push_back('{exp: e, name: nm});
    valid   = 1'b1;
    address = a;
    wstrobe = 4'b0000;
    step();
  endtask

  // Check irq during the current cycle (no time consumed).
  task automatic chk_irq(input logic e, input string nm);
    irq_q.push_back('{exp: {31'b0, e}, name: nm});
    probe = 1'b1;
  endtask

  // Monitor: compare every presented read and irq probe against the queues.
  always @(negedge clk) begin : monitor
    exp_t x;
    if (probe) begin
      n_cmp++;
      if (irq_q.size() == 0) begin
        n_mism++;
        $display("FAIL irq_probe: irq=%0d with no expectation queued", irq);
      end else begin
        x = irq_q.pop_front();
        if ({31'b0, irq} !== x.exp) begin
          n_mism++;
          $display("FAIL %s: irq=%0d expected %0d", x.name, irq, x.exp[0]);
        end
      end
    end
    if (valid && wstrobe == 4'b0000) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_mism++;
        $display("FAIL read: rdata=%08h with no expectation queued", rdata);
      end else begin
        x = rd_q.pop_front();
        if (rdata !== x.exp || ready !== 1'b1) begin
          n_mism++;
          $display("FAIL %s: rdata=%08h ready=%0d expected rdata=%08h ready=1",
                   x.name, rdata, ready, x.exp);
        end else begin
          $display("read %s addr=%08h rdata=%08h ok", x.name, address, rdata);
        end
      end
    end
    if (done) begin
      n_cmp++;
      if (rd_q.size() != 0 || irq_q.size() != 0) begin
        n_mism++;
        $display("FAIL drain: %0d reads and %0d irq checks never presented",
                 rd_q.size(), irq_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
      $finish;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    chk_irq(1'b0, "reset_irq");
    rd(32'h0, 32'h0, "reset_pending");
    rd(32'h4, 32'h0, "reset_enable");
    rd(32'h8, 32'h0, "reset_cause");
    rd(32'hC, 32'h0, "reset_edge");

    // Edge source 0: latency, ack, mret, W1C.
    wr(32'h4, 32'h1, 4'hF);
    wr(32'hC, 32'h1, 4'hF);
    sources[0] = 1'b1; step(); sources[0] = 1'b0;
    chk_irq(1'b0, "t1_lat1"); step();
    chk_irq(1'b0, "t1_lat2"); step();
    chk_irq(1'b0, "t1_lat3"); step();
    chk_irq(1'b1, "t1_irq_at_4"); irq_ack = 1'b1; step();
    chk_irq(1'b0, "t1_irq_after_ack");
    rd(32'h8, 32'h8000_0000, "t1_cause_insvc");
    mret = 1'b1; step();
    rd(32'h8, 32'h0, "t1_cause_after_mret");
    chk_irq(1'b1, "t1_rereq_pending_held");
    rd(32'h0, 32'h1, "t1_pending_held");
    wr(32'h0, 32'h1, 4'hF);
    rd(32'h0, 32'h0, "t1_pending_w1c");
    chk_irq(1'b0, "t1_irq_dropped"); step();

    // Level sources 2 and 3: priority, then back-to-back with 2-cycle gap.
    wr(32'hC, 32'h0, 4'hF);
    wr(32'h4, 32'h0C, 4'hF);
    sources = 8'h0C; steps(4);
    chk_irq(1'b1, "t2_irq"); irq_ack = 1'b1; step();
    rd(32'h8, 32'h8000_0002, "t2_cause_prio");
    sources = 8'h08; steps(4);
    chk_irq(1'b0, "t2_insvc_quiet"); mret = 1'b1; step();
    chk_irq(1'b0, "t2_idle_gap"); step();
    chk_irq(1'b1, "t2_rereq"); irq_ack = 1'b1; step();
    rd(32'h8, 32'h8000_0003, "t2_cause_next");
    sources = 8'h00; steps(4);
    mret = 1'b1; step();
    steps(2);
    chk_irq(1'b0, "t2_quiet"); step();

    // Masking during REQUEST withdraws the request; pending survives.
    wr(32'hC, 32'h2, 4'hF);
    wr(32'h4, 32'h2, 4'hF);
    sources[1] = 1'b1; step(); sources[1] = 1'b0;
    steps(3);
    chk_irq(1'b1, "t3_irq");
    wr(32'h4, 32'h0, 4'hF);
    step();
    chk_irq(1'b0, "t3_withdrawn");
    rd(32'h0, 32'h2, "t3_pending_kept");
    chk_irq(1'b0, "t3_stays_idle");
    rd(32'h8, 32'h3, "t3_cause_idle");

    // New rising edge in the same cycle as W1C: set wins.
    wr(32'hC, 32'h1, 4'hF);
    sources[0] = 1'b1; step(); sources[0] = 1'b0;
    steps(4);
    rd(32'h0, 32'h1, "t4_pending_first");
    sources[0] = 1'b1; step(); sources[0] = 1'b0;
    step();
    wr(32'h0, 32'h1, 4'hF);
    chk_irq(1'b0, "t4_masked");
    rd(32'h0, 32'h1, "t4_set_wins");
    wr(32'h0, 32'h1, 4'hF);
    rd(32'h0, 32'h0, "t4_w1c_clears");

    // ack+mret together in REQUEST, stray ack/mret in IDLE.
    wr(32'h4, 32'h1, 4'hF);
    sources[0] = 1'b1; step(); sources[0] = 1'b0;
    steps(3);
    chk_irq(1'b1, "t5_irq");
    irq_ack = 1'b1; mret = 1'b1; step();
    chk_irq(1'b0, "t5_ack_wins");
    rd(32'h8, 32'h8000_0000, "t5_cause_insvc");
    wr(32'h0, 32'h1, 4'hF);
    mret = 1'b1; step();
    irq_ack = 1'b1; step();
    mret = 1'b1; step();
    chk_irq(1'b0, "t5_idle_ignore");
    rd(32'h8, 32'h0, "t5_cause_idle");

    // Async reset in the middle of service.
    sources[0] = 1'b1; step(); sources[0] = 1'b0;
    steps(3);
    chk_irq(1'b1, "t6_irq");
    irq_ack = 1'b1; step();
    rd(32'h8, 32'h8000_0000, "t6_cause_pre_reset");
    #2;
    reset = 1'b1;
    chk_irq(1'b0, "t6_rst_irq");
    rd(32'h0, 32'h0, "t6_rst_pending");
    rd(32'h8, 32'h0, "t6_rst_cause");
    rd(32'h4, 32'h0, "t6_rst_enable");
    reset = 1'b0;
    step();

    // Byte strobes, unimplemented bits and address aliasing.
    wr(32'h4, 32'hFFFF_FFFF, 4'b0001);
    rd(32'h4, 32'h0000_00FF, "t7_byte_strobe");
    wr(32'h4, 32'h0000_0000, 4'b0010);
    rd(32'h14, 32'h0000_00FF, "t7_alias_read");
    wr(32'h1C, 32'h0000_005A, 4'hF);
    rd(32'hC, 32'h0000_005A, "t7_alias_write");
    wr(32'h4, 32'h0000_00A5, 4'b1110);
    rd(32'h4, 32'h0000_00FF, "t7_strobe_mask");
    chk_irq(1'b0, "t7_no_irq"); step();

    done = 1'b1;
    repeat (3) @(posedge clk);
  end

endmodule
